// File: rtl/pe_operand_feeder.sv
// Operand-pair buffer that streams (image, weight) pairs into the first MAC PE, then runs the PE_finish/stop handshake.
// Optional FEEDER_TC2SM_EN: converts two's-complement write data to sign-magnitude before storing it.
module pe_operand_feeder #(
  parameter int dec_part      = 3,
  parameter int mantissa_part = 12,
  parameter int DEPTH         = 16,
  localparam int W  = dec_part + mantissa_part + 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_image,
  input  logic [W-1:0]  wr_weight,
  output logic          wr_ready,
  input  logic          start,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic [W-1:0]  image,
  output logic [W-1:0]  weight,
  output logic          init,
  output logic          PE_finish,
  input  logic          stop,
  output logic          done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state, next_state;

  logic [W-1:0]  mem_image [DEPTH];
  logic [W-1:0]  mem_weight[DEPTH];
  logic [AW-1:0] rd_ptr, rd_ptr_d;
  logic [AW-1:0] rd_next;
  logic [W-1:0]  image_d, weight_d;
  logic [CW-1:0] count_d;
  logic          init_d, pe_finish_d, done_d;
  logic          wr_fire, last;
  logic [W-1:0]  store_image, store_weight;

`ifdef FEEDER_TC2SM_EN
  // Most-negative input has no positive counterpart; saturate its magnitude.
  function automatic logic [W-1:0] to_sm(input logic [W-1:0] x);
    logic [W-1:0] neg;
    neg = ~x + W'(1);
    if (!x[W-1])
      return x;
    else if (x[W-2:0] == '0)
      return {1'b1, {(W-1){1'b1}}};
    else
      return {1'b1, neg[W-2:0]};
  endfunction

  assign store_image  = to_sm(wr_image);
  assign store_weight = to_sm(wr_weight);
`else
  assign store_image  = wr_image;
  assign store_weight = wr_weight;
`endif

  assign wr_ready = (state == IDLE) && (count < CW'(DEPTH)) && !start;
  assign wr_fire  = wr_en && wr_ready;
  assign last     = (CW'(rd_ptr) == count - CW'(1));
  assign rd_next  = rd_ptr + AW'(1);

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      image     <= '0;
      weight    <= '0;
      init      <= 1'b0;
      PE_finish <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != IDLE);
      count     <= count_d;
      rd_ptr    <= rd_ptr_d;
      image     <= image_d;
      weight    <= weight_d;
      init      <= init_d;
      PE_finish <= pe_finish_d;
      done      <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_image[count[AW-1:0]]  <= store_image;
      mem_weight[count[AW-1:0]] <= store_weight;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start && count != '0) next_state = STREAM;
      STREAM:  if (last) next_state = FINISH;
      FINISH:  if (stop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    image_d     = image;
    weight_d    = weight;
    init_d      = init;
    pe_finish_d = PE_finish;
    done_d      = 1'b0;
    count_d     = count;
    rd_ptr_d    = rd_ptr;
    case (state)
      IDLE: begin
        if (wr_fire) count_d = count + CW'(1);
        if (start && count != '0) begin
          rd_ptr_d = '0;
          image_d  = mem_image[0];
          weight_d = mem_weight[0];
          init_d   = 1'b1;
        end
      end
      STREAM: begin
        if (last) begin
          init_d      = 1'b0;
          image_d     = '0;
          weight_d    = '0;
          pe_finish_d = 1'b1;
        end else begin
          rd_ptr_d = rd_next;
          image_d  = mem_image[rd_next];
          weight_d = mem_weight[rd_next];
          init_d   = 1'b1;
        end
      end
      FINISH: begin
        // Buffer contents stay; clearing count is what invalidates them.
        if (stop) begin
          pe_finish_d = 1'b0;
          done_d      = 1'b1;
          count_d     = '0;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder: directed writes queue expected stream pairs, a negedge monitor checks them.
module tb_pe_operand_feeder;
  logic        clock = 1'b0;
  logic        rstn, wr_en, start, stop;
  logic [15:0] wr_image, wr_weight, image, weight;
  logic        wr_ready, busy, init, PE_finish, done;
  logic [4:0]  count;

  typedef struct {logic [15:0] img; logic [15:0] wgt;} pair_t;
  pair_t exp_q[$];
  pair_t buf_m[$];
  int total = 0, bad = 0;
  int done_seen = 0, done_exp = 0;

  always #5 clock = ~clock;

  pe_operand_feeder dut (
    .clock(clock), .rstn(rstn), .wr_en(wr_en), .wr_image(wr_image), .wr_weight(wr_weight),
    .wr_ready(wr_ready), .start(start), .busy(busy), .count(count), .image(image),
    .weight(weight), .init(init), .PE_finish(PE_finish), .stop(stop), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    pair_t p;
    if (done === 1'b1) done_seen++;
    if (init === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_init: got image %0h weight %0h expected no stream", image, weight);
      end else begin
        p = exp_q.pop_front();
        chk("stream_image", {16'h0, image}, {16'h0, p.img});
        chk("stream_weight", {16'h0, weight}, {16'h0, p.wgt});
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] b,
                    input logic [15:0] ea, input logic [15:0] eb, input bit acc);
    wr_en = 1'b1; wr_image = a; wr_weight = b;
    @(posedge clock); #1;
    wr_en = 1'b0;
    if (acc) buf_m.push_back('{ea, eb});
  endtask

  task automatic load_exp(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(buf_m[i]);
    buf_m.delete();
  endtask

  task automatic start_run(input int n);
    load_exp(n);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("init_high", {31'h0, init}, 32'h1);
      chk("busy_stream", {31'h0, busy}, 32'h1);
      @(posedge clock); #1;
    end
    chk("init_low_after", {31'h0, init}, 32'h0);
    chk("pe_finish_set", {31'h0, PE_finish}, 32'h1);
    chk("image_cleared", {16'h0, image}, 32'h0);
  endtask

  task automatic finish_run(input bit pre);
    if (!pre) stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    done_exp++;
    chk("done_pulse", {31'h0, done}, 32'h1);
    chk("pe_finish_clr", {31'h0, PE_finish}, 32'h0);
    chk("count_clr", {27'h0, count}, 32'h0);
    chk("busy_clr", {31'h0, busy}, 32'h0);
    chk("wr_ready_back", {31'h0, wr_ready}, 32'h1);
    @(posedge clock); #1;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    wr_image = '0; wr_weight = '0;
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    chk("rst_image", {16'h0, image}, 32'h0);
    chk("rst_weight", {16'h0, weight}, 32'h0);
    chk("rst_init", {31'h0, init}, 32'h0);
    chk("rst_pe_finish", {31'h0, PE_finish}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_count", {27'h0, count}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);

    // Three pairs, PE_finish held, then stop.
    wr(16'h0800, 16'h1000, 16'h0800, 16'h1000, 1);
`ifdef FEEDER_TC2SM_EN
    wr(16'h8800, 16'h0400, 16'hF800, 16'h0400, 1);
    wr(16'h0001, 16'h8001, 16'h0001, 16'hFFFF, 1);
`else
    wr(16'h8800, 16'h0400, 16'h8800, 16'h0400, 1);
    wr(16'h0001, 16'h8001, 16'h0001, 16'h8001, 1);
`endif
    chk("count_three", {27'h0, count}, 32'h3);
    start_run(3);
    @(posedge clock); #1;
    chk("pe_finish_held", {31'h0, PE_finish}, 32'h1);
    chk("busy_finish", {31'h0, busy}, 32'h1);
    finish_run(0);

    // Fill to DEPTH, drop the overflow write, stop already high before FINISH.
    for (int i = 0; i < 16; i++)
      wr(16'h0100 + 16'(i), 16'h0200 + 16'(i * 3), 16'h0100 + 16'(i), 16'h0200 + 16'(i * 3), 1);
    chk("count_full", {27'h0, count}, 32'd16);
    chk("wr_ready_full", {31'h0, wr_ready}, 32'h0);
    wr(16'h1234, 16'h4321, 16'h0, 16'h0, 0);
    chk("count_overflow", {27'h0, count}, 32'd16);
    stop = 1'b1;
    start_run(16);
    finish_run(1);

    // Start with empty buffer is ignored.
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("empty_start_busy", {31'h0, busy}, 32'h0);
    chk("empty_start_init", {31'h0, init}, 32'h0);

    // Start and write together: start wins.
    wr(16'h0055, 16'h00AA, 16'h0055, 16'h00AA, 1);
    wr(16'h8123, 16'h0321, 16'h8123, 16'h0321, 1);
`ifdef FEEDER_TC2SM_EN
    begin
      pair_t p = buf_m[1];
      p.img = 16'hFEDD;
      buf_m[1] = p;
    end
`endif
    load_exp(2);
    start = 1'b1; wr_en = 1'b1; wr_image = 16'h7777; wr_weight = 16'h7777;
    @(posedge clock); #1;
    start = 1'b0; wr_en = 1'b0;
    chk("collide_count", {27'h0, count}, 32'h2);
    chk("collide_init0", {31'h0, init}, 32'h1);
    @(posedge clock); #1;
    chk("collide_init1", {31'h0, init}, 32'h1);
    @(posedge clock); #1;
    chk("collide_finish", {31'h0, PE_finish}, 32'h1);
    finish_run(0);

    // Reset during the second STREAM cycle abandons the run.
    wr(16'h0011, 16'h0022, 16'h0011, 16'h0022, 1);
    wr(16'h0033, 16'h0044, 16'h0033, 16'h0044, 1);
    wr(16'h0055, 16'h0066, 16'h0055, 16'h0066, 1);
    load_exp(2);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    rstn = 1'b0;
    @(posedge clock); #1;
    rstn = 1'b1;
    chk("abort_init", {31'h0, init}, 32'h0);
    chk("abort_image", {16'h0, image}, 32'h0);
    chk("abort_weight", {16'h0, weight}, 32'h0);
    chk("abort_pe_finish", {31'h0, PE_finish}, 32'h0);
    chk("abort_count", {27'h0, count}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_wr_ready", {31'h0, wr_ready}, 32'h1);
    repeat (4) @(posedge clock);
    #1;
    chk("abort_no_done", {31'h0, done}, 32'h0);

    // Sign handling at write.
`ifdef FEEDER_TC2SM_EN
    wr(16'hF800, 16'h8000, 16'h8800, 16'hFFFF, 1);
`else
    wr(16'h8000, 16'hF800, 16'h8000, 16'hF800, 1);
`endif
    wr(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
    start_run(2);
    finish_run(0);

    chk("queue_drained", exp_q.size(), 32'h0);
    chk("done_total", done_seen, done_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
